ps2_key_matrix: RTL and testbench

Parametrised PS/2 keyboard receiver and key-state tracker, fully synchronous to `clk_50m`. It oversamples and filters the raw `kclk`/`kdata` pins and receives complete 11-bit frames with start, parity and stop checking and a timeout. It decodes the E0 (extended) and F0 (break) prefixes and keeps an independent held/released bit per mapped key, so keys held at the same time are all reported. It sits between the board PS/2 pins and the game logic, and the player button vectors are slices of `keys_held`.

---
 rtl/ps2_key_matrix.sv | 223 ++++++++++++++++++++++
 tb/tb_ps2_key_matrix.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_matrix.sv
// PS/2 keyboard receiver with input filtering, frame checking, E0/F0 prefix
// decoding and an independent held/released bit for every mapped key.
module ps2_key_matrix #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int NUM_KEYS    = 10,
  parameter logic [NUM_KEYS*9-1:0] KEYMAP = {
    9'h070, 9'h174, 9'h16B, 9'h172, 9'h175,
    9'h029, 9'h023, 9'h01C, 9'h01B, 9'h01D}
) (
  input  logic                    clk_50m,
  input  logic                    rst,
  input  logic                    kclk,
  input  logic                    kdata,
  output logic [NUM_KEYS-1:0]     keys_held,
  output logic                    key_event,
  output logic [((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0] key_event_idx,
  output logic                    key_event_make,
  output logic                    scan_valid,
  output logic [7:0]              scan_code,
  output logic                    frame_err
);

  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] kclk_sync, kdata_sync;
  logic                   kclk_s, kdata_s;
  logic                   kclk_filt;
  logic [FW-1:0]          filt_cnt;
  logic                   kclk_fall;
  logic [TW-1:0]          to_cnt;
  logic                   tmo_s;
  state_t                 state, state_nx;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par;
  logic                   good_s, err_s;
  logic                   ext, brk;
  logic [NUM_KEYS-1:0]    keys_nx_s, chg_s;
  logic [IW-1:0]          ev_idx_s;
  logic                   ev_make_s;

  assign kclk_s  = kclk_sync[SYNC_STAGES-1];
  assign kdata_s = kdata_sync[SYNC_STAGES-1];

  // A falling edge is the cycle in which the filter commits a 1->0 change.
  assign kclk_fall = kclk_filt & ~kclk_s & (filt_cnt == FW'(FILT_LEN - 1));

  // Timeout only applies while a frame is in progress.
  assign tmo_s = (state != IDLE) && !kclk_fall && (to_cnt >= TW'(TIMEOUT_CYC - 1));

  // Metastability synchronisers for both raw pins; idle bus level is 1.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      kclk_sync  <= '1;
      kdata_sync <= '1;
    end else begin
      kclk_sync  <= {kclk_sync[SYNC_STAGES-2:0], kclk};
      kdata_sync <= {kdata_sync[SYNC_STAGES-2:0], kdata};
    end
  end

  // Glitch filter: flip only after FILT_LEN consecutive disagreeing samples.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      kclk_filt <= 1'b1;
      filt_cnt  <= '0;
    end else if (kclk_s == kclk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      kclk_filt <= kclk_s;
      filt_cnt  <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // Cycles since the last falling edge; loading 1 on the edge makes the
  // count equal the elapsed cycles, so the error lands exactly on time.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (kclk_fall) begin
      to_cnt <= TW'(1);
    end else if (to_cnt != TW'(TIMEOUT_CYC)) begin
      to_cnt <= to_cnt + TW'(1);
    end else begin
      to_cnt <= to_cnt;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Frame FSM next state and good/error frame decisions.
  always_comb begin
    state_nx = state;
    good_s   = 1'b0;
    err_s    = 1'b0;
    if (tmo_s) begin
      state_nx = IDLE;
      err_s    = 1'b1;
    end else if (kclk_fall) begin
      case (state)
        IDLE: begin
          if (!kdata_s) state_nx = DATA;
          else          err_s    = 1'b1;
        end
        DATA: begin
          if (bit_cnt == 3'd7) state_nx = PARITY;
          else                 state_nx = DATA;
        end
        PARITY: state_nx = STOP;
        STOP: begin
          state_nx = IDLE;
          if (kdata_s && (^{shreg, par})) good_s = 1'b1;
          else                            err_s  = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end else begin
      state_nx = state;
    end
  end

  // Frame datapath: LSB-first shift register, bit counter and parity bit.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      shreg   <= 8'h00;
      bit_cnt <= 3'd0;
      par     <= 1'b0;
    end else if (tmo_s) begin
      shreg   <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (kclk_fall) begin
      case (state)
        IDLE:    bit_cnt <= 3'd0;
        DATA: begin
          shreg   <= {kdata_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        PARITY:  par <= kdata_s;
        default: par <= par;
      endcase
    end
  end

  // Registered frame result strobes and the last good byte.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      scan_code  <= 8'h00;
    end else begin
      scan_valid <= good_s;
      frame_err  <= err_s;
      if (good_s) scan_code <= shreg;
    end
  end

  // Key map lookup: new held vector and lowest changed index.
  always_comb begin
    keys_nx_s = keys_held;
    ev_idx_s  = '0;
    ev_make_s = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      keys_nx_s[k] = (KEYMAP[9*k +: 9] == {ext, scan_code}) ? ~brk : keys_held[k];
    end
    chg_s = keys_nx_s ^ keys_held;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      ev_idx_s  = chg_s[k] ? IW'(k) : ev_idx_s;
      ev_make_s = chg_s[k] ? keys_nx_s[k] : ev_make_s;
    end
  end

  // Decoder: prefix flags, keyboard-reset bytes and key state updates.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      keys_held      <= '0;
      key_event      <= 1'b0;
      key_event_idx  <= '0;
      key_event_make <= 1'b0;
      ext            <= 1'b0;
      brk            <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (scan_valid) begin
        case (scan_code)
          8'hE0: ext <= 1'b1;
          8'hF0: brk <= 1'b1;
          8'hE1: ext <= ext;
          8'hAA, 8'h00, 8'hFF: begin
            keys_held <= '0;
            ext       <= 1'b0;
            brk       <= 1'b0;
          end
          default: begin
            keys_held <= keys_nx_s;
            ext       <= 1'b0;
            brk       <= 1'b0;
            if (|chg_s) begin
              key_event      <= 1'b1;
              key_event_idx  <= ev_idx_s;
              key_event_make <= ev_make_s;
            end
          end
        endcase
      end else if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Self-checking bench for ps2_key_matrix: table of frames plus hand-written
// timeout, glitch and asynchronous reset sequences, with a pulse scoreboard.
module tb_ps2_key_matrix;

  localparam int TMO = 400;

  logic       clk_50m = 1'b0;
  logic       rst     = 1'b1;
  logic       kclk    = 1'b1;
  logic       kdata   = 1'b1;
  logic [9:0] keys_held;
  logic       key_event;
  logic [3:0] key_event_idx;
  logic       key_event_make;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       frame_err;

  ps2_key_matrix #(.SYNC_STAGES(2), .FILT_LEN(8), .TIMEOUT_CYC(TMO), .NUM_KEYS(10)) dut (
    .clk_50m(clk_50m), .rst(rst), .kclk(kclk), .kdata(kdata),
    .keys_held(keys_held), .key_event(key_event), .key_event_idx(key_event_idx),
    .key_event_make(key_event_make), .scan_valid(scan_valid), .scan_code(scan_code),
    .frame_err(frame_err));

  always #5 clk_50m = ~clk_50m;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int err_cyc = 0;
  int n_fall = 0;
  int err_exp = 0;
  logic [7:0] sv_q[$];
  logic [4:0] ev_q[$];

  typedef struct {
    logic [7:0] code;
    logic       par_ok;
    logic       stop_ok;
    logic [9:0] keys_exp;
    int         ev_idx;
    logic       ev_make;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk_50m) cyc <= cyc + 1;

  // Scoreboard: every output pulse must match a queued expectation.
  always @(negedge clk_50m) begin
    logic [7:0] e8;
    logic [4:0] e5;
    if (dut.kclk_fall) begin
      fall_cyc = cyc;
      n_fall++;
    end
    if (scan_valid) begin
      if (sv_q.size() == 0) chk("unexpected_scan_valid", {24'h0, scan_code}, 32'h100);
      else begin
        e8 = sv_q.pop_front();
        chk("scan_code", {24'h0, scan_code}, {24'h0, e8});
      end
    end
    if (frame_err) begin
      err_cyc = cyc;
      if (err_exp == 0) chk("unexpected_frame_err", 32'd1, 32'd0);
      else begin
        err_exp--;
        n_cmp++;
      end
    end
    if (key_event) begin
      if (ev_q.size() == 0) chk("unexpected_key_event", {27'h0, key_event_make, key_event_idx}, 32'h100);
      else begin
        e5 = ev_q.pop_front();
        chk("key_event_make_idx", {27'h0, key_event_make, key_event_idx}, {27'h0, e5});
      end
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50m);
      kdata = bits[i];
      repeat (10) @(negedge clk_50m);
      kclk = 1'b0;
      repeat (20) @(negedge clk_50m);
      kclk = 1'b1;
      repeat (10) @(negedge clk_50m);
    end
    kdata = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par_ok, input logic stop_ok);
    logic p;
    p = par_ok ? ~(^code) : (^code);
    send_bits({stop_ok, p, code, 1'b0}, 11);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    if (v.par_ok && v.stop_ok) sv_q.push_back(v.code);
    else                       err_exp++;
    if (v.ev_idx >= 0) ev_q.push_back({v.ev_make, v.ev_idx[3:0]});
    send_frame(v.code, v.par_ok, v.stop_ok);
    repeat (10) @(negedge clk_50m);
    chk({nm, "_keys_held"}, {22'h0, keys_held}, {22'h0, v.keys_exp});
    chk({nm, "_pending"}, sv_q.size() + ev_q.size() + err_exp, 32'd0);
  endtask

  initial begin
    int n0;
    int waited;
    vec_t v;

    // code, parity ok, stop ok, expected keys_held, event index (-1 none), make
    vecs.push_back('{8'h1D, 1'b1, 1'b1, 10'h001,  0, 1'b1});
    vecs.push_back('{8'hF0, 1'b1, 1'b1, 10'h001, -1, 1'b0});
    vecs.push_back('{8'h1D, 1'b1, 1'b1, 10'h000,  0, 1'b0});
    vecs.push_back('{8'h1D, 1'b1, 1'b1, 10'h001,  0, 1'b1});
    vecs.push_back('{8'hE0, 1'b1, 1'b1, 10'h001, -1, 1'b0});
    vecs.push_back('{8'h75, 1'b1, 1'b1, 10'h021,  5, 1'b1});
    vecs.push_back('{8'h29, 1'b1, 1'b1, 10'h031,  4, 1'b1});
    vecs.push_back('{8'hE0, 1'b1, 1'b1, 10'h031, -1, 1'b0});
    vecs.push_back('{8'hF0, 1'b1, 1'b1, 10'h031, -1, 1'b0});
    vecs.push_back('{8'h75, 1'b1, 1'b1, 10'h011,  5, 1'b0});
    vecs.push_back('{8'h1D, 1'b0, 1'b1, 10'h011, -1, 1'b0});
    vecs.push_back('{8'h1D, 1'b1, 1'b0, 10'h011, -1, 1'b0});
    vecs.push_back('{8'hE0, 1'b1, 1'b1, 10'h011, -1, 1'b0});
    vecs.push_back('{8'h1D, 1'b0, 1'b1, 10'h011, -1, 1'b0});
    vecs.push_back('{8'h1B, 1'b1, 1'b1, 10'h013,  1, 1'b1});
    vecs.push_back('{8'h75, 1'b1, 1'b1, 10'h013, -1, 1'b0});
    vecs.push_back('{8'h1D, 1'b1, 1'b1, 10'h013, -1, 1'b0});
    vecs.push_back('{8'h1D, 1'b1, 1'b1, 10'h013, -1, 1'b0});
    vecs.push_back('{8'h1C, 1'b1, 1'b1, 10'h017,  2, 1'b1});
    vecs.push_back('{8'h23, 1'b1, 1'b1, 10'h01F,  3, 1'b1});
    vecs.push_back('{8'hE0, 1'b1, 1'b1, 10'h01F, -1, 1'b0});
    vecs.push_back('{8'h75, 1'b1, 1'b1, 10'h03F,  5, 1'b1});
    vecs.push_back('{8'hE0, 1'b1, 1'b1, 10'h03F, -1, 1'b0});
    vecs.push_back('{8'h72, 1'b1, 1'b1, 10'h07F,  6, 1'b1});
    vecs.push_back('{8'hE0, 1'b1, 1'b1, 10'h07F, -1, 1'b0});
    vecs.push_back('{8'h6B, 1'b1, 1'b1, 10'h0FF,  7, 1'b1});
    vecs.push_back('{8'hE0, 1'b1, 1'b1, 10'h0FF, -1, 1'b0});
    vecs.push_back('{8'h74, 1'b1, 1'b1, 10'h1FF,  8, 1'b1});
    vecs.push_back('{8'h70, 1'b1, 1'b1, 10'h3FF,  9, 1'b1});
    vecs.push_back('{8'hAA, 1'b1, 1'b1, 10'h000, -1, 1'b0});

    // Reset state.
    repeat (3) @(negedge clk_50m);
    chk("reset_keys_held", {22'h0, keys_held}, 32'h0);
    chk("reset_pulses", {29'h0, scan_valid, frame_err, key_event}, 32'h0);
    chk("reset_scan_code", {24'h0, scan_code}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk_50m);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Partial frame then silence: error exactly TMO cycles after the last edge.
    err_exp++;
    send_bits({3'b111, 8'h1B, 1'b0}, 6);
    waited = 0;
    while (err_exp != 0 && waited < TMO + 200) begin
      @(negedge clk_50m);
      waited++;
    end
    chk("timeout_seen", err_exp, 32'd0);
    chk("timeout_delay", err_cyc - fall_cyc, TMO);
    v = '{8'h1B, 1'b1, 1'b1, 10'h002, 1, 1'b1};
    run_vec(v, "after_timeout");

    // Short kclk glitch must not produce a falling edge.
    n0 = n_fall;
    @(negedge clk_50m);
    kclk = 1'b0;
    repeat (6) @(negedge clk_50m);
    kclk = 1'b1;
    repeat (40) @(negedge clk_50m);
    chk("glitch_no_fall", n_fall - n0, 32'd0);

    // Asynchronous reset in the middle of a data byte.
    v = '{8'h1D, 1'b1, 1'b1, 10'h003, 0, 1'b1};
    run_vec(v, "before_reset");
    send_bits({3'b111, 8'h1C, 1'b0}, 4);
    kdata = 1'b1;
    repeat (10) @(negedge clk_50m);
    kclk = 1'b0;
    repeat (5) @(negedge clk_50m);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_keys_held", {22'h0, keys_held}, 32'h0);
    chk("async_rst_scan_code", {24'h0, scan_code}, 32'h0);
    chk("async_rst_pulses", {29'h0, scan_valid, frame_err, key_event}, 32'h0);
    kclk = 1'b1;
    kdata = 1'b1;
    repeat (5) @(negedge clk_50m);
    rst = 1'b0;
    repeat (20) @(negedge clk_50m);
    v = '{8'h23, 1'b1, 1'b1, 10'h008, 3, 1'b1};
    run_vec(v, "after_reset");

    repeat (20) @(negedge clk_50m);
    chk("final_pending", sv_q.size() + ev_q.size() + err_exp, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
